press_decoder: RTL and testbench

Input-side counterpart of the LED blink generator. It debounces the keypad push-button and times each press, classifying it as short (0) or long (1). Consecutive presses are packed into a code word, which is delivered to the lock controller through a valid/ack handshake once the user pauses. The blinker turns durations into light; this block turns press durations back into data.

---
 rtl/press_decoder.sv | 148 ++++++++++++++
 tb/tb_press_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/press_decoder.sv
// Debounces the keypad button, classifies each press as short (0) or long (1),
// and hands the packed code to the lock controller over a valid/ack handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no code in progress, outputs cleared, waiting for a press
// PRESS    | button held, press timer running
// GAP      | button released, gap timer running toward end of code
// VALID    | code presented, frozen until code_ack
// WAIT_REL | acked while still held, wait for release without counting
module press_decoder #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 6000000,
    parameter int GAP_CYCLES      = 12000000,
    parameter int MAX_SYMBOLS     = 8
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       btn,
    output logic [7:0] code,
    output logic [3:0] code_len,
    output logic       overflow,
    output logic       code_valid,
    input  logic       code_ack,
    output logic       busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(LONG_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DB_LOAD    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRESS_LOAD = PW'(LONG_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LEN_MAX    = 4'(MAX_SYMBOLS);

    typedef enum logic [2:0] {IDLE, PRESS, GAP, VALID, WAIT_REL} state_t;

    state_t          state;
    logic [1:0]      sync_q;
    logic            db;
    logic [DW-1:0]   db_left;
    logic [PW-1:0]   press_left;
    logic [GW-1:0]   gap_left;
    logic            symbol;

    // The rise cycle seen in IDLE/GAP already counts as one held cycle,
    // so the press timer is loaded one short of LONG_CYCLES.
    assign symbol = (press_left == '0);

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            db      <= 1'b0;
            db_left <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
            if (sync_q[1] != db) begin
                if (db_left == '0) begin
                    db      <= sync_q[1];
                    db_left <= DB_LOAD;
                end else begin
                    db_left <= db_left - DW'(1);
                end
            end else begin
                db_left <= DB_LOAD;
            end
        end
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            press_left <= '0;
            gap_left   <= '0;
            code       <= '0;
            code_len   <= '0;
            overflow   <= 1'b0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    code     <= '0;
                    code_len <= '0;
                    overflow <= 1'b0;
                    if (db) begin
                        state      <= PRESS;
                        busy       <= 1'b1;
                        press_left <= PRESS_LOAD;
                    end
                end
                PRESS: begin
                    if (!db) begin
                        if (code_len < LEN_MAX) begin
                            code[code_len[2:0]] <= symbol;
                            code_len            <= code_len + 4'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        gap_left <= GAP_LOAD;
                        state    <= GAP;
                    end else if (press_left != '0) begin
                        press_left <= press_left - PW'(1);
                    end
                end
                GAP: begin
                    if (db) begin
                        state      <= PRESS;
                        press_left <= PRESS_LOAD;
                    end else if (gap_left == '0) begin
                        state      <= VALID;
                        code_valid <= 1'b1;
                    end else begin
                        gap_left <= gap_left - GW'(1);
                    end
                end
                VALID: begin
                    if (code_ack) begin
                        code_valid <= 1'b0;
                        code       <= '0;
                        code_len   <= '0;
                        overflow   <= 1'b0;
                        if (db) begin
                            state <= WAIT_REL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                WAIT_REL: begin
                    code     <= '0;
                    code_len <= '0;
                    overflow <= 1'b0;
                    if (!db) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_decoder.sv
// Directed bench for press_decoder with short timing parameters
// (debounce 4, long 20, gap 40).
module tb_press_decoder;

    logic       hwclk = 1'b0;
    logic       rst;
    logic       btn;
    logic [7:0] code;
    logic [3:0] code_len;
    logic       overflow;
    logic       code_valid;
    logic       code_ack;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    press_decoder #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .GAP_CYCLES(40),
        .MAX_SYMBOLS(8)
    ) dut (
        .hwclk(hwclk),
        .rst(rst),
        .btn(btn),
        .code(code),
        .code_len(code_len),
        .overflow(overflow),
        .code_valid(code_valid),
        .code_ack(code_ack),
        .busy(busy)
    );

    always #5 hwclk = ~hwclk;

    // All stimulus tasks start and end just after a falling edge.
    task automatic idle_cycles(input int n);
        repeat (n) @(negedge hwclk);
    endtask

    task automatic press(input int n);
        btn = 1'b1;
        repeat (n) @(negedge hwclk);
        btn = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge hwclk);
            if (code_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic ack_pulse;
        code_ack = 1'b1;
        @(negedge hwclk);
        code_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; btn = 1'b0; code_ack = 1'b0;
        idle_cycles(3);
        n_checks++;
        if ({code, code_len, overflow, code_valid, busy} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got code=%h len=%0d ovf=%b valid=%b busy=%b, want all 0",
                     code, code_len, overflow, code_valid, busy);
        end
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_short;
        int cyc;
        press(10);
        wait_valid(cyc);
        n_checks++;
        if (cyc !== 47) begin
            n_fail++;
            $display("FAIL short_latency: valid after %0d cycles from btn release, want 47 (0=timeout)", cyc);
        end
        idle_cycles(3);
        n_checks++;
        if (code_valid !== 1'b1 || code !== 8'h00 || code_len !== 4'd1 || overflow !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL short_code: valid=%b code=%h len=%0d ovf=%b busy=%b, want 1 00 1 0 1",
                     code_valid, code, code_len, overflow, busy);
        end
        ack_pulse();
        n_checks++;
        if (code_valid !== 1'b0 || busy !== 1'b0 || code_len !== 4'd0) begin
            n_fail++;
            $display("FAIL short_ack: valid=%b busy=%b len=%0d, want 0 0 0", code_valid, busy, code_len);
        end
        idle_cycles(5);
    endtask

    task automatic test_sequence;
        int cyc;
        press(10); idle_cycles(15);
        press(30); idle_cycles(15);
        press(20);
        wait_valid(cyc);
        n_checks++;
        if (cyc == 0 || code !== 8'h06 || code_len !== 4'd3 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_slls: cyc=%0d code=%h len=%0d ovf=%b, want code 06 len 3 ovf 0",
                     cyc, code, code_len, overflow);
        end
        ack_pulse();
        idle_cycles(5);
        press(19); idle_cycles(15);
        press(20);
        wait_valid(cyc);
        n_checks++;
        if (cyc == 0 || code !== 8'h02 || code_len !== 4'd2) begin
            n_fail++;
            $display("FAIL long_boundary: cyc=%0d code=%h len=%0d, want code 02 len 2", cyc, code, code_len);
        end
        ack_pulse();
        idle_cycles(5);
    endtask

    task automatic test_glitch;
        int cyc;
        int lv [4] = '{1, 0, 1, 0};
        int dur[4] = '{3, 6, 3, 6};
        for (int i = 0; i < 4; i++) begin
            btn = lv[i][0];
            idle_cycles(dur[i]);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_ignored: busy=%b, want 0", busy);
        end
        press(1); idle_cycles(1);
        press(12); idle_cycles(1);
        press(1);
        wait_valid(cyc);
        n_checks++;
        if (cyc == 0 || code !== 8'h00 || code_len !== 4'd1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_press: cyc=%0d code=%h len=%0d ovf=%b, want 00 1 0", cyc, code, code_len, overflow);
        end
        ack_pulse();
        idle_cycles(5);
    endtask

    task automatic test_overflow;
        int cyc;
        for (int i = 0; i < 9; i++) begin
            press(25);
            if (i < 8) idle_cycles(10);
        end
        wait_valid(cyc);
        n_checks++;
        if (cyc == 0 || code !== 8'hFF || code_len !== 4'd8 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow9: cyc=%0d code=%h len=%0d ovf=%b, want FF 8 1", cyc, code, code_len, overflow);
        end
        ack_pulse();
        n_checks++;
        if (overflow !== 1'b0 || code_len !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: ovf=%b len=%0d busy=%b, want 0 0 0", overflow, code_len, busy);
        end
        idle_cycles(5);
    endtask

    task automatic test_wait_rel;
        int cyc;
        press(10);
        wait_valid(cyc);
        btn = 1'b1;
        idle_cycles(12);
        n_checks++;
        if (cyc == 0 || code_valid !== 1'b1 || code_len !== 4'd1) begin
            n_fail++;
            $display("FAIL valid_frozen: cyc=%0d valid=%b len=%0d, want valid 1 len 1", cyc, code_valid, code_len);
        end
        ack_pulse();
        idle_cycles(10);
        n_checks++;
        if (busy !== 1'b1 || code_len !== 4'd0 || code_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_rel_held: busy=%b len=%0d valid=%b, want 1 0 0", busy, code_len, code_valid);
        end
        btn = 1'b0;
        idle_cycles(10);
        n_checks++;
        if (busy !== 1'b0 || code_len !== 4'd0) begin
            n_fail++;
            $display("FAIL wait_rel_release: busy=%b len=%0d, want 0 0", busy, code_len);
        end
        idle_cycles(60);
        n_checks++;
        if (code_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_not_counted: valid=%b busy=%b, want 0 0", code_valid, busy);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        press(10); idle_cycles(15);
        press(25); idle_cycles(15);
        btn = 1'b1;
        idle_cycles(10);
        n_checks++;
        if (code_len !== 4'd2 || busy !== 1'b1 || code !== 8'h02) begin
            n_fail++;
            $display("FAIL pre_reset: len=%0d busy=%b code=%h, want 2 1 02", code_len, busy, code);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({code, code_len, overflow, code_valid, busy} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset: code=%h len=%0d ovf=%b valid=%b busy=%b, want all 0",
                     code, code_len, overflow, code_valid, busy);
        end
        btn = 1'b0;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(3);
        press(20);
        wait_valid(cyc);
        n_checks++;
        if (cyc == 0 || code !== 8'h01 || code_len !== 4'd1) begin
            n_fail++;
            $display("FAIL after_reset: cyc=%0d code=%h len=%0d, want 01 1", cyc, code, code_len);
        end
        ack_pulse();
        idle_cycles(5);
    endtask

    task automatic test_back_to_back;
        int cyc;
        code_ack = 1'b1;
        press(10);
        wait_valid(cyc);
        n_checks++;
        if (cyc !== 47 || code_len !== 4'd1) begin
            n_fail++;
            $display("FAIL ack_tied_valid: cyc=%0d len=%0d, want 47 1", cyc, code_len);
        end
        @(negedge hwclk);
        n_checks++;
        if (code_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_tied_pulse: valid=%b busy=%b, want 0 0", code_valid, busy);
        end
        idle_cycles(60);
        n_checks++;
        if (code_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_tied_no_repeat: valid=%b, want 0", code_valid);
        end
        code_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_short();
        test_sequence();
        test_glitch();
        test_overflow();
        test_wait_rel();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
